// File: rtl/seq_det_pkg.sv
// Shared types, default parameters and width helpers for the unlock-sequence detector.
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    DRAIN   = 3'd2,
    BACKOFF = 3'd3,
    LOCKED  = 3'd4
  } det_state_t;

  localparam int unsigned DEF_PAT_LEN      = 11;
  localparam logic [10:0] DEF_PATTERN      = 11'b000_1001_0100;
  localparam int unsigned DEF_MAX_FAILS    = 3;
  localparam int unsigned DEF_BACKOFF_BASE = 4;
  localparam bit          DEF_STICKY_LOCK  = 1'b1;

  // Position counter must hold 0..pat_len so an over-long frame is visible.
  function automatic int unsigned pos_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Failure counter holds 0..max_fails.
  function automatic int unsigned fc_width(input int unsigned max_fails);
    return $clog2(max_fails + 1);
  endfunction

  // Back-off counter sized for the longest shifted back-off length.
  function automatic int unsigned bo_width(input int unsigned base, input int unsigned max_fails);
    return $clog2(base << (max_fails - 1)) + 1;
  endfunction

endpackage

// File: rtl/seq_lock_detector_if.sv
// Serial attempt input and status outputs of the unlock-sequence detector.
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int unsigned FC_W = fc_width(DEF_MAX_FAILS)
) ();

  logic            in_valid;
  logic            in_bit;
  logic            in_last;
  logic            in_ready;
  logic            detect;
  logic            fail;
  logic            locked;
  logic [FC_W-1:0] fail_count;

  modport master (
    output in_valid, in_bit, in_last,
    input  in_ready, detect, fail, locked, fail_count
  );

  modport slave (
    input  in_valid, in_bit, in_last,
    output in_ready, detect, fail, locked, fail_count
  );

endinterface

// File: rtl/seq_lock_detector_backoff_timer.sv
// Back-off down-counter: loads base << (fails-1) on start, flags the final cycle.
module backoff_timer
  import seq_det_pkg::*;
#(
  parameter int unsigned BACKOFF_BASE = DEF_BACKOFF_BASE,
  parameter int unsigned MAX_FAILS    = DEF_MAX_FAILS,
  localparam int unsigned FC_W        = fc_width(MAX_FAILS),
  localparam int unsigned CNT_W       = bo_width(BACKOFF_BASE, MAX_FAILS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [FC_W-1:0] fails_i,
  output logic            done_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] load_val;

  assign load_val = CNT_W'(BACKOFF_BASE) << (fails_i - FC_W'(1));

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Load on start, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // A count of one is the last back-off cycle; zero guards a degenerate base.
  assign done_c_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/seq_lock_detector.sv
// Framed serial unlock-sequence detector with exponential back-off and lockout.
module seq_lock_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned        PAT_LEN      = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN      = PAT_LEN'(DEF_PATTERN),
  parameter int unsigned        MAX_FAILS    = DEF_MAX_FAILS,
  parameter int unsigned        BACKOFF_BASE = DEF_BACKOFF_BASE,
  parameter bit                 STICKY_LOCK  = DEF_STICKY_LOCK
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_det_if.slave bus
);

  localparam int unsigned POS_W = pos_width(PAT_LEN);
  localparam int unsigned FC_W  = fc_width(MAX_FAILS);

  det_state_t         state_q;
  det_state_t         state_d;
  logic [POS_W-1:0]   pos_q;
  logic [POS_W-1:0]   pos_d;
  logic [FC_W-1:0]    fail_count_q;
  logic [FC_W-1:0]    fail_count_d;
  logic [FC_W-1:0]    fails_new;
  logic               detect_q;
  logic               detect_d;
  logic               fail_q;
  logic               fail_d;
  // Power-up value; a sticky lock must not depend on reset to start cleared.
  logic               locked_q = 1'b0;
  logic               locked_d;
  logic               in_ready_c;
  logic               accept;
  logic               bit_ok;
  logic               frame_ok;
  logic               frame_fail;
  logic               bo_start;
  logic               bo_done;
  logic [PAT_LEN-1:0] pat_shift;

  assign in_ready_c = (state_q == IDLE) || (state_q == RECV) || (state_q == DRAIN);
  assign accept     = bus.in_valid && in_ready_c;
  assign fails_new  = fail_count_q + FC_W'(1);

  // MSB of the shifted pattern is the bit expected at the current position.
  assign pat_shift = PATTERN << pos_q;
  assign bit_ok    = (pos_q < POS_W'(PAT_LEN)) && (bus.in_bit == pat_shift[PAT_LEN-1]);
  assign frame_ok  = bit_ok && (pos_q == POS_W'(PAT_LEN - 1));

  // State and status registers; a sticky lock survives reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      detect_q <= 1'b0;
      fail_q   <= 1'b0;
      pos_q    <= '0;
      if (STICKY_LOCK && locked_q) begin
        state_q      <= LOCKED;
        fail_count_q <= FC_W'(MAX_FAILS);
        locked_q     <= 1'b1;
      end else begin
        state_q      <= IDLE;
        fail_count_q <= '0;
        locked_q     <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      fail_count_q <= fail_count_d;
      detect_q     <= detect_d;
      fail_q       <= fail_d;
      locked_q     <= locked_d;
    end
  end

  // Next-state, match tracking and failure accounting.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    fail_count_d = fail_count_q;
    detect_d     = 1'b0;
    fail_d       = 1'b0;
    locked_d     = locked_q;
    bo_start     = 1'b0;
    frame_fail   = 1'b0;

    unique case (state_q)
      IDLE, RECV: begin
        if (accept) begin
          if (bus.in_last) begin
            pos_d = '0;
            if (frame_ok) begin
              detect_d     = 1'b1;
              fail_count_d = '0;
              state_d      = IDLE;
            end else begin
              frame_fail = 1'b1;
            end
          end else if (bit_ok) begin
            pos_d   = pos_q + POS_W'(1);
            state_d = RECV;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && bus.in_last) begin
          pos_d      = '0;
          frame_fail = 1'b1;
        end
      end
      BACKOFF: begin
        if (bo_done) begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any unsuccessful frame end: count it, then lock out or back off.
    if (frame_fail) begin
      fail_d       = 1'b1;
      fail_count_d = fails_new;
      if (fails_new == FC_W'(MAX_FAILS)) begin
        state_d  = LOCKED;
        locked_d = 1'b1;
      end else begin
        state_d  = BACKOFF;
        bo_start = 1'b1;
      end
    end
  end

  backoff_timer #(
    .BACKOFF_BASE(BACKOFF_BASE),
    .MAX_FAILS   (MAX_FAILS)
  ) u_backoff_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (bo_start),
    .fails_i (fails_new),
    .done_c_o(bo_done)
  );

  assign bus.in_ready   = in_ready_c;
  assign bus.detect     = detect_q;
  assign bus.fail       = fail_q;
  assign bus.locked     = locked_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_seq_lock_detector.sv
// Bench for seq_lock_detector: sticky and non-sticky instances against a frame-level model.
module tb_seq_lock_detector;
  import seq_det_pkg::*;

  localparam int unsigned PAT_LEN   = 11;
  localparam logic [10:0] PAT       = 11'b000_1001_0100;
  localparam int unsigned MAX_FAILS = 3;
  localparam int unsigned BASE      = 4;
  localparam int unsigned FC_W      = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tb_valid = 1'b0;
  logic tb_bit   = 1'b0;
  logic tb_last  = 1'b0;
  bit   chk_en   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_det_if #(.FC_W(FC_W)) bus_s ();
  seq_det_if #(.FC_W(FC_W)) bus_n ();

  assign bus_s.in_valid = tb_valid;
  assign bus_s.in_bit   = tb_bit;
  assign bus_s.in_last  = tb_last;
  assign bus_n.in_valid = tb_valid;
  assign bus_n.in_bit   = tb_bit;
  assign bus_n.in_last  = tb_last;

  seq_lock_detector #(
    .PAT_LEN(PAT_LEN), .PATTERN(PAT), .MAX_FAILS(MAX_FAILS),
    .BACKOFF_BASE(BASE), .STICKY_LOCK(1'b1)
  ) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  seq_lock_detector #(
    .PAT_LEN(PAT_LEN), .PATTERN(PAT), .MAX_FAILS(MAX_FAILS),
    .BACKOFF_BASE(BASE), .STICKY_LOCK(1'b0)
  ) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

  // Reference model per instance: index 0 sticky, index 1 non-sticky.
  bit m_locked [2];
  int m_fails  [2];
  int m_bo     [2];
  bit m_det    [2];
  bit m_fail   [2];
  bit m_frame  [2][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int i);
    return !m_locked[i] && (m_bo[i] == 0);
  endfunction

  function automatic bit frame_is_pattern(input bit f[$]);
    logic [10:0] p;
    p = PAT;
    if (f.size() != PAT_LEN) return 1'b0;
    for (int k = 0; k < PAT_LEN; k++) begin
      if (f[k] != p[PAT_LEN-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_det[i]  = 1'b0;
      m_fail[i] = 1'b0;
      if (!rst_n) begin
        if (!(i == 0 && m_locked[i])) begin
          m_locked[i] = 1'b0;
          m_fails[i]  = 0;
          m_bo[i]     = 0;
        end
        m_frame[i].delete();
      end else if (m_locked[i]) begin
        m_bo[i] = 0;
      end else if (m_bo[i] > 0) begin
        m_bo[i] = m_bo[i] - 1;
      end else if (tb_valid) begin
        m_frame[i].push_back(tb_bit);
        if (tb_last) begin
          if (frame_is_pattern(m_frame[i])) begin
            m_det[i]   = 1'b1;
            m_fails[i] = 0;
          end else begin
            m_fail[i]  = 1'b1;
            m_fails[i] = m_fails[i] + 1;
            if (m_fails[i] == MAX_FAILS) m_locked[i] = 1'b1;
            else m_bo[i] = BASE << (m_fails[i] - 1);
          end
          m_frame[i].delete();
        end
      end
    end
  end

  task automatic check_dut(input int i, input string nm, input logic r, input logic d,
                           input logic f, input logic l, input logic [FC_W-1:0] fc);
    check({nm, ".in_ready"},   32'(r),  32'(m_ready(i)));
    check({nm, ".detect"},     32'(d),  32'(m_det[i]));
    check({nm, ".fail"},       32'(f),  32'(m_fail[i]));
    check({nm, ".locked"},     32'(l),  32'(m_locked[i]));
    check({nm, ".fail_count"}, 32'(fc), 32'(m_fails[i]));
  endtask

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, "sticky", bus_s.in_ready, bus_s.detect, bus_s.fail, bus_s.locked, bus_s.fail_count);
      check_dut(1, "plain",  bus_n.in_ready, bus_n.detect, bus_n.fail, bus_n.locked, bus_n.fail_count);
    end
  end

  // Hold a bit until the non-sticky model accepts it or the budget runs out.
  task automatic send_bit(input bit b, input bit last, input int budget, output bit ok);
    bit acc;
    ok = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      tb_valid = 1'b0;
      @(negedge clk);
    end
    tb_valid = 1'b1;
    tb_bit   = b;
    tb_last  = last;
    for (int c = 0; c < budget; c++) begin
      acc = m_ready(1);
      @(negedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    tb_valid = 1'b0;
    tb_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int len, input bit with_last,
                            input int budget, output bit ok);
    bit one;
    ok = 1'b1;
    for (int k = 0; k < len; k++) begin
      send_bit(bits[len-1-k], with_last && (k == len - 1), budget, one);
      if (!one) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic backoff_len(output int n);
    n = 0;
    while (!bus_n.in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int n;
    int t;
    int len;
    logic [31:0] bits;
    logic [31:0] pat32;
    pat32 = 32'(PAT);

    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("rst_ready", 32'(bus_n.in_ready), 32'd1);
    check("rst_locked", 32'(bus_s.locked), 32'd0);
    check("rst_fc", 32'(bus_s.fail_count), 32'd0);

    // Correct frame.
    send_frame(pat32, 11, 1'b1, 40, ok);
    check("accept_good", 32'(ok), 32'd1);
    check("good_detect", 32'(bus_n.detect), 32'd1);
    check("good_fc", 32'(bus_n.fail_count), 32'd0);
    check("good_ready", 32'(bus_n.in_ready), 32'd1);

    // Bit 4 flipped: drained to the end, then a 4-cycle back-off.
    send_frame(32'b000_0001_0100, 11, 1'b1, 40, ok);
    check("accept_flip", 32'(ok), 32'd1);
    check("flip_fail", 32'(bus_n.fail), 32'd1);
    check("flip_fc", 32'(bus_n.fail_count), 32'd1);
    backoff_len(n);
    check("flip_backoff", 32'(n), 32'd4);

    send_frame(pat32, 11, 1'b1, 40, ok);
    check("clear_fc", 32'(bus_n.fail_count), 32'd0);

    // Short then long frame, second back-off doubles.
    send_frame(pat32 >> 1, 10, 1'b1, 40, ok);
    check("short_fail", 32'(bus_n.fail), 32'd1);
    backoff_len(n);
    check("short_backoff", 32'(n), 32'd4);
    send_frame({pat32[30:0], 1'b1}, 12, 1'b1, 40, ok);
    check("long_fail", 32'(bus_n.fail), 32'd1);
    check("long_fc", 32'(bus_n.fail_count), 32'd2);
    backoff_len(n);
    check("long_backoff", 32'(n), 32'd8);
    send_frame(pat32, 11, 1'b1, 40, ok);
    check("recover_detect", 32'(bus_n.detect), 32'd1);
    check("recover_fc", 32'(bus_n.fail_count), 32'd0);

    // Reset after six matching bits discards progress.
    send_frame(pat32 >> 5, 6, 1'b0, 40, ok);
    do_reset();
    send_frame(pat32, 11, 1'b1, 40, ok);
    check("midrst_detect", 32'(bus_n.detect), 32'd1);
    check("midrst_fc", 32'(bus_n.fail_count), 32'd0);

    // Randomized frames, steering away from lockout.
    for (int f = 0; f < 30; f++) begin
      t = int'($urandom_range(0, 2));
      if (m_fails[1] == int'(MAX_FAILS) - 1) t = 0;
      if (t == 0) begin
        bits = pat32; len = 11;
      end else if (t == 1) begin
        bits = pat32 ^ (32'd1 << $urandom_range(0, 10)); len = 11;
      end else begin
        len = int'($urandom_range(1, 13)); bits = $urandom;
      end
      send_frame(bits, len, 1'b1, 40, ok);
      check("accept_rand", 32'(ok), 32'd1);
    end

    // Make sure both instances start the lockout run from zero failures.
    send_frame(pat32, 11, 1'b1, 40, ok);
    repeat (3) begin
      send_frame(32'b000_0001_0100, 11, 1'b1, 40, ok);
    end
    check("lock_locked", 32'(bus_s.locked), 32'd1);
    check("lock_fc", 32'(bus_s.fail_count), 32'd3);
    check("lock_ready", 32'(bus_s.in_ready), 32'd0);
    send_frame(pat32, 11, 1'b1, 20, ok);
    check("lock_nodetect", 32'(bus_s.detect), 32'd0);
    check("lock_fc_hold", 32'(bus_n.fail_count), 32'd3);

    // Reset while locked: only the sticky instance stays locked.
    do_reset();
    check("sticky_locked", 32'(bus_s.locked), 32'd1);
    check("sticky_ready", 32'(bus_s.in_ready), 32'd0);
    check("sticky_fc", 32'(bus_s.fail_count), 32'd3);
    check("plain_locked", 32'(bus_n.locked), 32'd0);
    check("plain_ready", 32'(bus_n.in_ready), 32'd1);
    check("plain_fc", 32'(bus_n.fail_count), 32'd0);
    send_frame(pat32, 11, 1'b1, 40, ok);
    check("post_detect", 32'(bus_n.detect), 32'd1);
    check("post_sticky_nodetect", 32'(bus_s.detect), 32'd0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_lock_detector.md
# seq_lock_detector

Parametrised serial unlock-sequence detector for the security path. It checks framed bit-serial attempts against an elaboration-time pattern and pulses `detect` on an exact match. Each failed attempt triggers an exponentially growing back-off. After `MAX_FAILS` consecutive failures the block enters a lockout, and that lockout can optionally survive reset.

## Interface
- `PAT_LEN`, 11: pattern length in bits (≥1).
- `PATTERN`, 11'b000_1001_0100: expected sequence; the first bit received is compared with `PATTERN[PAT_LEN-1]` (MSB first).
- `MAX_FAILS`, 3: consecutive failed attempts that cause lockout (≥1).
- `BACKOFF_BASE`, 4: back-off length in cycles after the first failure.
- `STICKY_LOCK`, 1: when 1, `rst_n` does not clear the lockout.

Ports:
- `clk` in 1: clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in_bit` is valid.
- `in_bit` in 1: serial data bit.
- `in_last` in 1: marks the final bit of an attempt frame.
- `in_ready` out 1: the block accepts a bit this cycle.
- `detect` out 1: one-cycle pulse on a successful match.
- `fail` out 1: one-cycle pulse on a failed attempt.
- `locked` out 1: lockout is active.
- `fail_count` out `$clog2(MAX_FAILS+1)`: consecutive-failure count.

## Operation
- A bit is accepted only when `in_valid && in_ready`. If `in_ready` is low, the sender holds its data; the block never drops an accepted bit.
- States:
  - `IDLE`: waiting for the first bit of a frame.
  - `RECV`: all bits so far match.
  - `DRAIN`: a mismatch has occurred; accept bits until `in_last`.
  - `BACKOFF`: `in_ready` = 0 while the back-off counter runs.
  - `LOCKED`: absorbing state.
- Position counter `pos` is `$clog2(PAT_LEN+1)` bits wide and clears at the start of each frame.
- Transitions on an accepted bit, in `IDLE` or `RECV`:
  - If the bit equals `PATTERN[PAT_LEN-1-pos]` and `pos < PAT_LEN`, increment `pos`.
  - Otherwise go to `DRAIN`.
- Frame end (accepted bit with `in_last`):
  - Success requires all bits matched and `pos+1 == PAT_LEN`.
  - Success: pulse `detect`, clear `fail_count`, return to `IDLE`.
  - Any other frame end is a failure: a short frame, a long frame, or a mismatch.
- On failure:
  - Pulse `fail` and increment `fail_count`.
  - If the new count equals `MAX_FAILS`, go to `LOCKED`.
  - Otherwise go to `BACKOFF` for `BACKOFF_BASE << (fail_count_new-1)` cycles, then return to `IDLE`.
- Back-off counter width is `$clog2(BACKOFF_BASE<<(MAX_FAILS-1))+1`. No saturation is needed.
- `LOCKED` behaviour:
  - `in_ready` = 0 and `locked` = 1.
  - `fail_count` holds at `MAX_FAILS`.
  - `detect` and `fail` never pulse.
- The lock flag has a power-up initial value of 0.

Reset (`rst_n` = 0 at a clock edge):
- `detect` = 0 and `fail` = 0.
- If `STICKY_LOCK` = 1 and the block is locked:
  - State stays `LOCKED`.
  - `locked` = 1, `in_ready` = 0, `fail_count` = `MAX_FAILS`.
- Otherwise:
  - State goes to `IDLE`.
  - `pos`, `fail_count` and the back-off counter are all 0.
  - `locked` = 0 and `in_ready` = 1.
- Reset mid-frame or mid-back-off discards progress and does not count as a failure.

## Timing
- `in_ready` is combinational from state: high in `IDLE`, `RECV` and `DRAIN`.
- `detect`, `fail`, `locked` and `fail_count` are registered. They update in the cycle after the clock edge that accepted the `in_last` bit.
- Back-off: `in_ready` goes low in the same cycle `fail` is high and stays low for exactly N cycles. It is high again in cycle N+1 after the fail pulse.
- A new frame may start in the cycle immediately after a success.
- A single-cycle frame (`in_last` on the first bit) is legal; it succeeds only if `PAT_LEN` = 1.
- Reset dominates all simultaneous events.

## Structure
- Package `seq_det_pkg` holds:
  - state enum `det_state_t` (`IDLE`, `RECV`, `DRAIN`, `BACKOFF`, `LOCKED`);
  - default parameter constants;
  - width helper functions.
- Sub-module `backoff_timer`:
  - loads the shift-computed count on `start`;
  - asserts `done` when the count expires;
  - clears on reset.

## Test plan
- Frame `00010010100` with `in_last` on bit 11 → `detect` = 1 for one cycle, `fail_count` = 0, `in_ready` stays 1.
- Frame with bit 4 flipped (`00000010100`) → bits 5–11 still accepted, `fail` pulses once, `fail_count` = 1, `in_ready` = 0 for 4 cycles.
- Short frame (10 bits) then long frame (12 bits) → two fails, second back-off is 8 cycles, `fail_count` = 2; then a correct frame → `detect`, `fail_count` = 0.
- Three bad frames → `locked` = 1, `fail_count` = 3, `in_ready` = 0; a correct frame is held off with no `detect`.
- With `STICKY_LOCK` = 1, pulse `rst_n` low while locked → still locked. With `STICKY_LOCK` = 0 → `IDLE`, `locked` = 0, `fail_count` = 0.
- Assert `rst_n` mid-frame after 6 matching bits, then send the full pattern → `detect` = 1, `fail_count` unchanged.
